// File: rtl/sprite_pixel_fetch_if.sv
// Pixel request, pattern ROM and resolved-pixel bundle for sprite_pixel_fetch.
// The slave modport is the fetch stage; the master is its environment.
interface sprite_pixel_fetch_if #(
    parameter int NSPR = 4,
    parameter int CHW  = (NSPR > 1) ? $clog2(NSPR) : 1
);
    logic               pix_en;
    logic [9:0]         hcount;
    logic [9:0]         vcount;
    logic [16*NSPR-1:0] spr_addr;
    logic [NSPR-1:0]    spr_valid;
    logic [7:0]         bg_idx;
    logic [15:0]        rom_addr;
    logic               rom_rd;
    logic [7:0]         rom_data;
    logic [7:0]         pix_idx;
    logic [9:0]         pix_hcount;
    logic [9:0]         pix_vcount;
    logic               out_valid;
    logic               sprite_hit;
    logic [CHW-1:0]     hit_ch;
    logic               busy;
    logic               overrun;
    logic               clr_overrun;

    modport master (
        output pix_en, hcount, vcount, spr_addr, spr_valid, bg_idx, rom_data, clr_overrun,
        input  rom_addr, rom_rd, pix_idx, pix_hcount, pix_vcount, out_valid,
               sprite_hit, hit_ch, busy, overrun
    );

    modport slave (
        input  pix_en, hcount, vcount, spr_addr, spr_valid, bg_idx, rom_data, clr_overrun,
        output rom_addr, rom_rd, pix_idx, pix_hcount, pix_vcount, out_valid,
               sprite_hit, hit_ch, busy, overrun
    );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite resolve: walks valid channels in priority order through the
// shared pattern ROM and emits the first opaque texel, else the background index.
module sprite_pixel_fetch #(
    parameter int         NSPR    = 4,
    parameter int         ROM_LAT = 2,
    parameter logic [7:0] TRANSP  = 8'h00,
    parameter int         CHW     = (NSPR > 1) ? $clog2(NSPR) : 1
) (
    input  logic                clk,
    input  logic                reset,
    sprite_pixel_fetch_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SCAN  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state;
    logic [NSPR-1:0][15:0] addr;
    logic [NSPR-1:0]       pend;
    logic [9:0]            hc;
    logic [9:0]            vc;
    logic [7:0]            bg;
    logic [CHW-1:0]        ch;
    logic [2:0]            wcnt;
    logic [7:0]            res_idx;
    logic                  res_hit;
    logic [CHW-1:0]        res_ch;
    logic [CHW-1:0]        low_ch;

    // Lowest pending channel wins; scanning downward leaves the smallest index.
    always_comb begin
        low_ch = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (pend[i]) low_ch = CHW'(i);
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            addr           <= '0;
            pend           <= '0;
            hc             <= '0;
            vc             <= '0;
            bg             <= '0;
            ch             <= '0;
            wcnt           <= '0;
            res_idx        <= '0;
            res_hit        <= 1'b0;
            res_ch         <= '0;
            bus.rom_addr   <= '0;
            bus.rom_rd     <= 1'b0;
            bus.pix_idx    <= '0;
            bus.pix_hcount <= '0;
            bus.pix_vcount <= '0;
            bus.out_valid  <= 1'b0;
            bus.sprite_hit <= 1'b0;
            bus.hit_ch     <= '0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.rom_rd    <= 1'b0;

            // A dropped request outranks a same-cycle clear.
            if (bus.pix_en && state != IDLE)
                bus.overrun <= 1'b1;
            else if (bus.clr_overrun)
                bus.overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.pix_en) begin
                        addr  <= bus.spr_addr;
                        pend  <= bus.spr_valid;
                        hc    <= bus.hcount;
                        vc    <= bus.vcount;
                        bg    <= bus.bg_idx;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (pend == '0) begin
                        res_idx <= bg;
                        res_hit <= 1'b0;
                        res_ch  <= '0;
                        state   <= DONE;
                    end else begin
                        // Address and strobe are registered here so they appear in ISSUE.
                        ch           <= low_ch;
                        pend[low_ch] <= 1'b0;
                        bus.rom_addr <= addr[low_ch];
                        bus.rom_rd   <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= 3'(ROM_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (wcnt == 3'd1) begin
                        if (bus.rom_data != TRANSP) begin
                            res_idx <= bus.rom_data;
                            res_hit <= 1'b1;
                            res_ch  <= ch;
                            state   <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                DONE: begin
                    bus.pix_idx    <= res_idx;
                    bus.pix_hcount <= hc;
                    bus.pix_vcount <= vc;
                    bus.sprite_hit <= res_hit;
                    bus.hit_ch     <= res_ch;
                    bus.out_valid  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch with a latency-accurate pattern ROM model.
module tb_sprite_pixel_fetch;
    localparam int NSPR    = 4;
    localparam int ROM_LAT = 2;
    localparam int CHW     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_pixel_fetch_if #(.NSPR(NSPR), .CHW(CHW)) bus ();

    sprite_pixel_fetch #(.NSPR(NSPR), .ROM_LAT(ROM_LAT), .TRANSP(8'h00), .CHW(CHW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // ROM: unmapped addresses are transparent; idle slots carry an opaque filler
    // so a mistimed sample shows up as a wrong index.
    logic [7:0] rom_mem [int unsigned];
    logic [7:0] rom_pipe [ROM_LAT];

    function automatic logic [7:0] rom_lookup(input logic [15:0] a);
        int unsigned k;
        k = {16'h0, a};
        return rom_mem.exists(k) ? rom_mem[k] : 8'h00;
    endfunction

    always @(posedge clk) begin
        rom_pipe[0] <= bus.rom_rd ? rom_lookup(bus.rom_addr) : 8'hEE;
        for (int i = ROM_LAT - 1; i > 0; i--) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data = rom_pipe[ROM_LAT-1];

    typedef struct {
        logic [7:0]     idx;
        logic [9:0]     hc;
        logic [9:0]     vc;
        logic           hit;
        logic [CHW-1:0] ch;
        int             cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pix_idx",    32'(bus.pix_idx),    32'(e.idx));
                chk("pix_hcount", 32'(bus.pix_hcount), 32'(e.hc));
                chk("pix_vcount", 32'(bus.pix_vcount), 32'(e.vc));
                chk("sprite_hit", 32'(bus.sprite_hit), 32'(e.hit));
                chk("hit_ch",     32'(bus.hit_ch),     32'(e.ch));
                chk("out_cycle",  32'(cyc),            32'(e.cyc));
            end
        end
    end

    task automatic set_addr(input int c, input logic [15:0] a);
        bus.spr_addr[16*c +: 16] = a;
    endtask

    // Presents one accepted request; returns #1 into cycle T+1 with inputs scrambled.
    task automatic issue(input logic [NSPR-1:0] vmask, input logic [9:0] h, input logic [9:0] v,
                         input logic [7:0] bg, input bit push, input logic [7:0] eidx,
                         input logic ehit, input logic [CHW-1:0] ech, input int lat);
        exp_t e;
        @(posedge clk); #1;
        bus.spr_valid = vmask;
        bus.hcount    = h;
        bus.vcount    = v;
        bus.bg_idx    = bg;
        bus.pix_en    = 1'b1;
        e.idx = eidx; e.hc = h; e.vc = v; e.hit = ehit; e.ch = ech; e.cyc = cyc + lat;
        if (push) q.push_back(e);
        @(posedge clk); #1;
        bus.pix_en    = 1'b0;
        bus.spr_valid = ~vmask;
        bus.spr_addr  = {$urandom, $urandom};
        bus.bg_idx    = ~bg;
        bus.hcount    = ~h;
        bus.vcount    = ~v;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("timeout_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_en = 1'b0; bus.hcount = '0; bus.vcount = '0; bus.spr_addr = '0;
        bus.spr_valid = '0; bus.bg_idx = '0; bus.clr_overrun = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_rom_rd",   32'(bus.rom_rd), 0);
        chk("rst_pix_idx",  32'(bus.pix_idx), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_overrun",  32'(bus.overrun), 0);
        rst_n = 1'b1;

        // Empty channels: background after 3 cycles
        issue(4'b0000, 10'd100, 10'd7, 8'h2A, 1, 8'h2A, 1'b0, 2'd0, 3);
        wait_done();

        // Single opaque channel 2; check ROM strobe timing
        rom_mem[32'h0123] = 8'h55;
        set_addr(2, 16'h0123);
        issue(4'b0100, 10'd5, 10'd6, 8'h11, 1, 8'h55, 1'b1, 2'd2, 6);
        @(negedge clk);
        chk("busy_T1",   32'(bus.busy), 1);
        chk("rom_rd_T1", 32'(bus.rom_rd), 0);
        @(negedge clk);
        chk("rom_rd_T2",   32'(bus.rom_rd), 1);
        chk("rom_addr_T2", 32'(bus.rom_addr), 32'h0123);
        @(negedge clk);
        chk("rom_rd_T3",   32'(bus.rom_rd), 0);
        chk("rom_addr_T3", 32'(bus.rom_addr), 32'h0123);
        wait_done();

        // Transparent ch0 falls through to ch1; ch3 opaque but lower priority
        rom_mem[32'h0200] = 8'h00; rom_mem[32'h0201] = 8'h17; rom_mem[32'h0203] = 8'h99;
        set_addr(0, 16'h0200); set_addr(1, 16'h0201); set_addr(3, 16'h0203);
        issue(4'b1011, 10'd640, 10'd479, 8'h01, 1, 8'h17, 1'b1, 2'd1, 10);
        wait_done();

        // Both opaque: channel 0 wins
        rom_mem[32'h0300] = 8'h41; rom_mem[32'h0301] = 8'h42;
        set_addr(0, 16'h0300); set_addr(1, 16'h0301);
        issue(4'b0011, 10'd1, 10'd2, 8'h01, 1, 8'h41, 1'b1, 2'd0, 6);
        wait_done();

        // All valid, all transparent: worst case
        for (int c = 0; c < NSPR; c++) set_addr(c, 16'h0400 + 16'(c));
        issue(4'b1111, 10'd1023, 10'd0, 8'h03, 1, 8'h03, 1'b0, 2'd0, 19);
        wait_done();

        // Overrun: second pix_en at T+3 is dropped
        rom_mem[32'h0500] = 8'h66;
        set_addr(0, 16'h0500);
        issue(4'b0001, 10'd300, 10'd200, 8'h09, 1, 8'h66, 1'b1, 2'd0, 6);
        step();
        bus.pix_en = 1'b1; bus.spr_valid = 4'b0000; bus.bg_idx = 8'hA5;
        step();
        bus.pix_en = 1'b0;
        wait_done();
        repeat (4) step();
        chk("overrun_set",    32'(bus.overrun), 1);
        chk("overrun_q_empty", 32'(q.size()), 0);

        // clr_overrun with a dropped pix_en: set wins
        issue(4'b0000, 10'd50, 10'd60, 8'h3C, 1, 8'h3C, 1'b0, 2'd0, 3);
        bus.pix_en = 1'b1; bus.clr_overrun = 1'b1;
        step();
        bus.pix_en = 1'b0; bus.clr_overrun = 1'b0;
        chk("overrun_set_wins_from1", 32'(bus.overrun), 1);
        wait_done();
        step();
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        chk("overrun_cleared", 32'(bus.overrun), 0);
        issue(4'b0000, 10'd51, 10'd61, 8'h3D, 1, 8'h3D, 1'b0, 2'd0, 3);
        bus.pix_en = 1'b1; bus.clr_overrun = 1'b1;
        step();
        bus.pix_en = 1'b0; bus.clr_overrun = 1'b0;
        chk("overrun_set_wins_from0", 32'(bus.overrun), 1);
        wait_done();

        // Reset mid-WAIT abandons the request and clears everything
        rom_mem[32'h0600] = 8'h77;
        set_addr(0, 16'h0600);
        issue(4'b0001, 10'd8, 10'd9, 8'h0F, 0, 8'h00, 1'b0, 2'd0, 0);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstw_busy",     32'(bus.busy), 0);
        chk("rstw_rom_addr", 32'(bus.rom_addr), 0);
        chk("rstw_pix_idx",  32'(bus.pix_idx), 0);
        chk("rstw_hcount",   32'(bus.pix_hcount), 0);
        chk("rstw_overrun",  32'(bus.overrun), 0);
        repeat (10) step();

        // Normal request after reset
        rom_mem[32'h0601] = 8'h78;
        set_addr(1, 16'h0601);
        issue(4'b0010, 10'd12, 10'd13, 8'h0F, 1, 8'h78, 1'b1, 2'd1, 6);
        wait_done();
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
